// File: rtl/pwm_capture.sv
// PWM capture: measures high time and period of pwm_in in prescaler ticks.
// Optional glitch filter enabled by defining PWM_CAPTURE_FILTER_EN.
module pwm_capture #(
  parameter int WIDTH       = 8,
  parameter int TIMER_WIDTH = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [TIMER_WIDTH-1:0] timer_final_value,
  input  logic                   pwm_in,
  output logic [WIDTH:0]         duty_meas,
  output logic [WIDTH:0]         period_meas,
  output logic                   meas_valid,
  output logic                   timeout,
  output logic                   level
);

  localparam int CW = WIDTH + 1;
  localparam logic [CW-1:0] SAT = '1;

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} state_t;

  state_t                 state_q;
  logic [1:0]             sync_q;
  logic [TIMER_WIDTH-1:0] presc_q;
  logic                   sample_q;
  logic                   sample_d;
  logic                   tick;
  logic [CW-1:0]          high_q;
  logic [CW-1:0]          period_q;
  logic [CW-1:0]          duty_q;
  logic [CW-1:0]          per_meas_q;
  logic                   valid_q;
  logic                   timeout_q;
  logic [CW-1:0]          high_inc;
  logic [CW-1:0]          period_inc;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == SAT) ? SAT : v + CW'(1);
  endfunction

  always_comb begin
    tick       = (presc_q >= timer_final_value);
    high_inc   = sat_inc(high_q);
    period_inc = sat_inc(period_q);
  end

`ifdef PWM_CAPTURE_FILTER_EN
  // Counts consecutive ticks on which the synced input disagrees with sample.
  logic [1:0] filt_q;

  always_comb begin
    sample_d = sample_q;
    if (tick && (sync_q[1] != sample_q) && (filt_q == 2'd2)) begin
      sample_d = sync_q[1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q <= 2'd0;
    end else if (tick) begin
      if ((sync_q[1] == sample_q) || (filt_q == 2'd2)) begin
        filt_q <= 2'd0;
      end else begin
        filt_q <= filt_q + 2'd1;
      end
    end
  end
`else
  always_comb begin
    sample_d = tick ? sync_q[1] : sample_q;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sync_q     <= 2'b00;
      presc_q    <= '0;
      sample_q   <= 1'b0;
      high_q     <= '0;
      period_q   <= '0;
      duty_q     <= '0;
      per_meas_q <= '0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], pwm_in};
      presc_q  <= tick ? '0 : presc_q + TIMER_WIDTH'(1);
      sample_q <= sample_d;
      valid_q  <= 1'b0;
      if (tick) begin
        case (state_q)
          S_IDLE: begin
            if (sample_d && !sample_q) begin
              high_q   <= CW'(1);
              period_q <= CW'(1);
              state_q  <= S_HIGH;
            end
          end
          S_HIGH: begin
            if (period_inc == SAT) begin
              timeout_q  <= 1'b1;
              duty_q     <= sample_d ? SAT : '0;
              per_meas_q <= SAT;
              valid_q    <= 1'b1;
              state_q    <= S_IDLE;
            end else begin
              period_q <= period_inc;
              if (sample_d) begin
                high_q <= high_inc;
              end else begin
                state_q <= S_LOW;
              end
            end
          end
          S_LOW: begin
            // In LOW the previous sample is 0, so a high sample is a rising edge.
            if (sample_d) begin
              duty_q     <= high_q;
              per_meas_q <= period_q;
              valid_q    <= 1'b1;
              timeout_q  <= 1'b0;
              high_q     <= CW'(1);
              period_q   <= CW'(1);
              state_q    <= S_HIGH;
            end else if (period_inc == SAT) begin
              timeout_q  <= 1'b1;
              duty_q     <= '0;
              per_meas_q <= SAT;
              valid_q    <= 1'b1;
              state_q    <= S_IDLE;
            end else begin
              period_q <= period_inc;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign duty_meas   = duty_q;
  assign period_meas = per_meas_q;
  assign meas_valid  = valid_q;
  assign timeout     = timeout_q;
  assign level       = sample_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: a behavioural PWM source drives pwm_in,
// expected measurements are queued with the stimulus and popped on meas_valid.
module tb_pwm_capture;

  logic        clk;
  logic        rst;
  logic [14:0] tfv;
  logic        pwm_in;
  logic [8:0]  duty_meas;
  logic [8:0]  period_meas;
  logic        meas_valid;
  logic        timeout;
  logic        level;

  pwm_capture #(.WIDTH(8), .TIMER_WIDTH(15)) dut (
    .clk               (clk),
    .rst               (rst),
    .timer_final_value (tfv),
    .pwm_in            (pwm_in),
    .duty_meas         (duty_meas),
    .period_meas       (period_meas),
    .meas_valid        (meas_valid),
    .timeout           (timeout),
    .level             (level)
  );

  typedef struct {
    int duty;
    int period;
    int to;
    int lvl;
    bit mask;   // duty/period not predicted for this entry
    int gap;    // required clk distance from previous meas_valid, 0 = any
  } exp_t;

  exp_t sb[$];
  int   n_err    = 0;
  int   n_checks = 0;
  int   n_valid  = 0;
  int   cyc      = 0;
  int   last_cyc = 0;

  // PWM source controls
  bit   gen_en     = 0;
  int   gen_high   = 0;
  int   gen_period = 0;
  int   gen_glitch = 0;
  int   gen_count  = 0;
  logic man_lvl    = 0;

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic push(input int d, input int p, input int to, input int lvl,
                      input bit mask, input int gap);
    exp_t e;
    e.duty = d; e.period = p; e.to = to; e.lvl = lvl; e.mask = mask; e.gap = gap;
    sb.push_back(e);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_val(tag, sb.size(), 0);
    if (sb.size() != 0) sb.delete();
    repeat (50) @(negedge clk);
  endtask

  task automatic start_gen(input int h, input int p, input int g);
    gen_high = h; gen_period = p; gen_glitch = g;
    gen_en = 1;
  endtask

  // Behavioural PWM source, changes pwm_in on falling clock edges.
  initial begin
    pwm_in = 0;
    forever begin
      if (gen_en) begin
        gen_count++;
        pwm_in = 1;
        repeat (gen_high) @(negedge clk);
        pwm_in = 0;
        if (gen_glitch > 0) begin
          repeat (gen_glitch - gen_high) @(negedge clk);
          pwm_in = 1;
          @(negedge clk);
          pwm_in = 0;
          repeat (gen_period - gen_glitch - 1) @(negedge clk);
        end else begin
          repeat (gen_period - gen_high) @(negedge clk);
        end
      end else begin
        pwm_in = man_lvl;
        @(negedge clk);
      end
    end
  end

  // Output monitor
  always @(negedge clk) begin
    if (!rst && meas_valid) begin
      n_valid++;
      $display("meas cyc=%0d duty=%0d period=%0d timeout=%0b level=%0b",
               cyc, duty_meas, period_meas, timeout, level);
      if (sb.size() == 0) begin
        check_val("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (!e.mask) begin
          check_val("duty_meas", int'(duty_meas), e.duty);
          check_val("period_meas", int'(period_meas), e.period);
        end
        check_val("timeout", int'(timeout), e.to);
        check_val("level", int'(level), e.lvl);
        if (e.gap != 0) check_val("valid_gap", cyc - last_cyc, e.gap);
      end
      last_cyc = cyc;
    end
  end

  initial begin
    int base;
    int n0;
    rst = 1;
    tfv = 15'd3;
    repeat (5) @(negedge clk);
    rst = 0;
    check_val("rst_duty", int'(duty_meas), 0);
    check_val("rst_period", int'(period_meas), 0);
    check_val("rst_valid", int'(meas_valid), 0);
    check_val("rst_timeout", int'(timeout), 0);
    check_val("rst_level", int'(level), 0);

    // Input held low: nothing is ever published.
    n0 = n_valid;
    repeat (3000) @(negedge clk);
    check_val("duty0_no_valid", n_valid - n0, 0);
    check_val("duty0_timeout", int'(timeout), 0);
    check_val("duty0_level", int'(level), 0);

    // Loop-back duty 64 of 256 ticks at 4 clk per tick, then stuck low.
    base = gen_count;
    push(64, 256, 0, 1, 0, 0);
    push(64, 256, 0, 1, 0, 1024);
    push(64, 256, 0, 1, 0, 1024);
    push(0, 511, 1, 0, 0, 0);
    start_gen(256, 1024, 0);
    wait (gen_count == base + 4);
    gen_en = 0;
    wait_drain("drain_loopback", 12000);
    check_val("stuck_low_timeout", int'(timeout), 1);
    check_val("stuck_low_level", int'(level), 0);

    // Stuck high with a tick every clk.
    tfv = 15'd0;
    push(511, 511, 1, 1, 0, 0);
    man_lvl = 1;
    wait_drain("drain_stuck_high", 2000);
    check_val("stuck_high_timeout", int'(timeout), 1);
    check_val("stuck_high_level", int'(level), 1);

    // Prescaler change 3 -> 1 mid-run. A 512-clk source period keeps the
    // doubled tick count (256) inside the 9-bit counter range.
    man_lvl = 0;
    repeat (20) @(negedge clk);
    tfv = 15'd3;
    base = gen_count;
    push(32, 128, 0, 1, 0, 0);
    push(32, 128, 0, 1, 0, 512);
    push(0, 0, 0, 1, 1, 0);
    push(64, 256, 0, 1, 0, 512);
    push(64, 256, 0, 1, 0, 512);
    push(0, 511, 1, 0, 0, 0);
    start_gen(128, 512, 0);
    wait (gen_count == base + 3);
    repeat (200) @(negedge clk);
    tfv = 15'd1;
    wait (gen_count == base + 6);
    gen_en = 0;
    wait_drain("drain_presc", 8000);

    // Reset during HIGH; the first edge after it only starts a measurement.
    tfv = 15'd3;
    base = gen_count;
    start_gen(256, 1024, 0);
    wait (gen_count == base + 1);
    repeat (100) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check_val("midrst_duty", int'(duty_meas), 0);
    check_val("midrst_period", int'(period_meas), 0);
    check_val("midrst_valid", int'(meas_valid), 0);
    check_val("midrst_timeout", int'(timeout), 0);
    check_val("midrst_level", int'(level), 0);
    push(0, 0, 0, 1, 1, 0);
    push(64, 256, 0, 1, 0, 1024);
    push(0, 511, 1, 0, 0, 0);
    wait (gen_count == base + 3);
    gen_en = 0;
    wait_drain("drain_midrst", 8000);

    tfv = 15'd0;
`ifndef PWM_CAPTURE_FILTER_EN
    // Minimum period: 1 tick high, 1 tick low.
    base = gen_count;
    push(1, 2, 0, 1, 0, 0);
    push(1, 2, 0, 1, 0, 2);
    push(1, 2, 0, 1, 0, 2);
    push(0, 511, 1, 0, 0, 0);
    start_gen(1, 2, 0);
    wait (gen_count == base + 4);
    gen_en = 0;
    wait_drain("drain_minperiod", 2000);

    // 1-tick glitch inside LOW splits each period.
    base = gen_count;
    push(10, 20, 0, 1, 0, 0);
    push(1, 20, 0, 1, 0, 20);
    push(10, 20, 0, 1, 0, 20);
    push(1, 20, 0, 1, 0, 20);
    push(10, 20, 0, 1, 0, 20);
    push(0, 511, 1, 0, 0, 0);
`else
    // 1-tick glitch inside LOW is rejected by the filter.
    base = gen_count;
    push(10, 40, 0, 1, 0, 0);
    push(10, 40, 0, 1, 0, 40);
    push(0, 511, 1, 0, 0, 0);
`endif
    start_gen(10, 40, 20);
    wait (gen_count == base + 3);
    gen_en = 0;
    wait_drain("drain_glitch", 2000);
    gen_glitch = 0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
